// File: rtl/can_fault_confinement_if.sv
// Event/status bundle between the CAN MAC, the host and the fault-confinement block.
interface can_fault_confinement_if #(
  parameter int CNT_W = 9
);
  // Error/success events and bus sampling from the MAC, recovery control from the host
  logic             tec_inc8;
  logic             tec_dec1;
  logic             rec_inc1;
  logic             rec_inc8;
  logic             rec_dec1;
  logic             bit_tick;
  logic             bus_level;
  logic             auto_recover;
  logic             recover_req;
  // Registered status towards the host register file
  logic [CNT_W-1:0] tec;
  logic [CNT_W-1:0] rec;
  logic [2:0]       fstate;
  logic             erroractive;
  logic             warnsig;
  logic             errorpassive;
  logic             busoff;
  logic             irqsig;
  logic [2:0]       irq_cause;

  modport master (
    output tec_inc8, tec_dec1, rec_inc1, rec_inc8, rec_dec1,
    output bit_tick, bus_level, auto_recover, recover_req,
    input  tec, rec, fstate, erroractive, warnsig, errorpassive, busoff,
    input  irqsig, irq_cause
  );

  modport slave (
    input  tec_inc8, tec_dec1, rec_inc1, rec_inc8, rec_dec1,
    input  bit_tick, bus_level, auto_recover, recover_req,
    output tec, rec, fstate, erroractive, warnsig, errorpassive, busoff,
    output irqsig, irq_cause
  );
endinterface

// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC counters, threshold FSM with multi-level jumps,
// host-gated or automatic bus-off recovery and a registered interrupt cause.
module can_fault_confinement #(
  parameter int CNT_W         = 9,
  parameter int WARN_LIMIT    = 96,
  parameter int PASSIVE_LIMIT = 128,
  parameter int BUSOFF_LIMIT  = 256,
  parameter int RECOV_EVENTS  = 128,
  parameter int RECOV_BITS    = 11
) (
  input logic                     clock_i,
  input logic                     reset_i,
  can_fault_confinement_if.slave  bus
);

  localparam int SEQ_W = $clog2(RECOV_BITS + 1);
  localparam int EVT_W = $clog2(RECOV_EVENTS + 1);

  // Thresholds at counter width (registered-counter compares) and at sum width
  localparam logic [CNT_W-1:0] WARN_C     = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] PASS_C     = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] BUSOFF_C   = CNT_W'(BUSOFF_LIMIT);
  localparam logic [CNT_W-1:0] REC_DROP_C = CNT_W'(PASSIVE_LIMIT - 9);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]   BUSOFF_X   = (CNT_W + 1)'(BUSOFF_LIMIT);
  localparam logic [CNT_W:0]   REC_MAX_X  = (CNT_W + 1)'((1 << CNT_W) - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST   = SEQ_W'(RECOV_BITS - 1);
  localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);
  localparam logic [EVT_W-1:0] EVT_END    = EVT_W'(RECOV_EVENTS);
  localparam logic [EVT_W-1:0] EVT_ONE    = EVT_W'(1);

  typedef enum logic [2:0] {
    ST_ACTIVE  = 3'd0,
    ST_WARNING = 3'd1,
    ST_PASSIVE = 3'd2,
    ST_BUSOFF  = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tec_q, tec_d;
  logic [CNT_W-1:0] rec_q, rec_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             pend_q, pend_d;
  logic             eact_q, eact_d;
  logic             warn_q, warn_d;
  logic             epas_q, epas_d;
  logic             boff_q, boff_d;
  logic             irq_q, irq_d;
  logic [2:0]       cause_q, cause_d;

  logic [CNT_W:0]   tec_sum;
  logic [CNT_W:0]   rec_inc;
  logic [CNT_W:0]   rec_sum;
  logic [CNT_W-1:0] tec_upd;
  logic [CNT_W-1:0] rec_upd;
  logic [CNT_W-1:0] cnt_max;

  // Saturating TEC/REC arithmetic for the current cycle's events
  always_comb begin
    tec_sum = {1'b0, tec_q}
            + {{(CNT_W-3){1'b0}}, bus.tec_inc8, 3'b000}
            - {{CNT_W{1'b0}}, bus.tec_dec1};
    if (bus.tec_dec1 && !bus.tec_inc8 && (tec_q == '0)) begin
      tec_upd = '0;
    end else if (tec_sum >= BUSOFF_X) begin
      tec_upd = BUSOFF_C;
    end else begin
      tec_upd = tec_sum[CNT_W-1:0];
    end

    rec_inc = {{(CNT_W-3){1'b0}}, bus.rec_inc8, 2'b00, bus.rec_inc1};
    rec_sum = {1'b0, rec_q} + rec_inc;
    if (rec_inc != '0) begin
      // Any increment overrides a simultaneous success event
      rec_upd = (rec_sum > REC_MAX_X) ? REC_MAX_X[CNT_W-1:0] : rec_sum[CNT_W-1:0];
    end else if (bus.rec_dec1) begin
      if (rec_q > PASS_C) begin
        rec_upd = REC_DROP_C;
      end else if (rec_q != '0) begin
        rec_upd = rec_q - CNT_ONE;
      end else begin
        rec_upd = rec_q;
      end
    end else begin
      rec_upd = rec_q;
    end

    cnt_max = (tec_q > rec_q) ? tec_q : rec_q;
  end

  // Next-state, counter ownership, recovery tracking and registered-output decode
  always_comb begin
    state_d = state_q;
    tec_d   = tec_q;
    rec_d   = rec_q;
    seq_d   = seq_q;
    evt_d   = evt_q;
    pend_d  = pend_q;
    eact_d  = 1'b0;
    warn_d  = 1'b0;
    epas_d  = 1'b0;
    boff_d  = 1'b0;

    case (state_q)
      ST_ACTIVE, ST_WARNING, ST_PASSIVE: begin
        tec_d  = tec_upd;
        rec_d  = rec_upd;
        seq_d  = '0;
        evt_d  = '0;
        pend_d = 1'b0;
        if (tec_q >= BUSOFF_C) begin
          state_d = ST_BUSOFF;
        end else if (cnt_max >= PASS_C) begin
          state_d = ST_PASSIVE;
        end else if (cnt_max >= WARN_C) begin
          state_d = ST_WARNING;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_BUSOFF: begin
        // Event inputs are frozen out; only bus sampling and host request matter
        if (bus.recover_req) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (bus.bit_tick) begin
          if (bus.bus_level) begin
            if (seq_q == SEQ_LAST) begin
              seq_d = '0;
              if (evt_q != EVT_END) begin
                evt_d = evt_q + EVT_ONE;
              end else begin
                evt_d = evt_q;
              end
            end else begin
              seq_d = seq_q + SEQ_ONE;
            end
          end else begin
            seq_d = '0;
          end
        end else begin
          seq_d = seq_q;
        end
        if ((evt_q == EVT_END) && (bus.auto_recover || pend_q)) begin
          state_d = ST_RECOVER;
        end else begin
          state_d = ST_BUSOFF;
        end
      end
      ST_RECOVER: begin
        tec_d   = '0;
        rec_d   = '0;
        seq_d   = '0;
        evt_d   = '0;
        pend_d  = 1'b0;
        state_d = ST_ACTIVE;
      end
      default: begin
        // Illegal encoding: counters untouched, fall back to ACTIVE
        state_d = ST_ACTIVE;
      end
    endcase

    // Flags follow the state being entered so they line up with fstate
    case (state_d)
      ST_ACTIVE:  eact_d = 1'b1;
      ST_WARNING: begin
        eact_d = 1'b1;
        warn_d = 1'b1;
      end
      ST_PASSIVE: epas_d = 1'b1;
      ST_BUSOFF:  boff_d = 1'b1;
      ST_RECOVER: eact_d = 1'b1;
      default: begin
        eact_d = 1'b0;
        warn_d = 1'b0;
        epas_d = 1'b0;
        boff_d = 1'b0;
      end
    endcase

    irq_d = (state_d != state_q);
    if (irq_d) begin
      cause_d = state_d;
    end else begin
      cause_d = cause_q;
    end
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_ACTIVE;
      tec_q   <= '0;
      rec_q   <= '0;
      seq_q   <= '0;
      evt_q   <= '0;
      pend_q  <= 1'b0;
      eact_q  <= 1'b1;
      warn_q  <= 1'b0;
      epas_q  <= 1'b0;
      boff_q  <= 1'b0;
      irq_q   <= 1'b0;
      cause_q <= 3'd0;
    end else begin
      state_q <= state_d;
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      seq_q   <= seq_d;
      evt_q   <= evt_d;
      pend_q  <= pend_d;
      eact_q  <= eact_d;
      warn_q  <= warn_d;
      epas_q  <= epas_d;
      boff_q  <= boff_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
    end
  end

  assign bus.tec          = tec_q;
  assign bus.rec          = rec_q;
  assign bus.fstate       = state_q;
  assign bus.erroractive  = eact_q;
  assign bus.warnsig      = warn_q;
  assign bus.errorpassive = epas_q;
  assign bus.busoff       = boff_q;
  assign bus.irqsig       = irq_q;
  assign bus.irq_cause    = cause_q;

endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed self-checking bench for can_fault_confinement.
module tb_can_fault_confinement;

  logic clock_i;
  logic reset_i;
  int   n_checks;
  int   n_fail;

  can_fault_confinement_if #(.CNT_W(9)) dut_if ();

  can_fault_confinement #(
    .CNT_W(9), .WARN_LIMIT(96), .PASSIVE_LIMIT(128), .BUSOFF_LIMIT(256),
    .RECOV_EVENTS(128), .RECOV_BITS(11)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (dut_if)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_inputs();
    dut_if.tec_inc8 = 1'b0; dut_if.tec_dec1 = 1'b0;
    dut_if.rec_inc1 = 1'b0; dut_if.rec_inc8 = 1'b0; dut_if.rec_dec1 = 1'b0;
    dut_if.bit_tick = 1'b0; dut_if.bus_level = 1'b1;
    dut_if.recover_req = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int st, input bit ea, input bit w,
                             input bit ep, input bit bo);
    check_val({tag, "_fstate"}, dut_if.fstate, st);
    check_val({tag, "_eact"}, dut_if.erroractive, ea);
    check_val({tag, "_warn"}, dut_if.warnsig, w);
    check_val({tag, "_epas"}, dut_if.errorpassive, ep);
    check_val({tag, "_boff"}, dut_if.busoff, bo);
  endtask

  task automatic check_irq(input string tag, input bit irq, input int cause);
    check_val({tag, "_irq"}, dut_if.irqsig, irq);
    check_val({tag, "_cause"}, dut_if.irq_cause, cause);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    dut_if.auto_recover = 1'b0;
    reset_i = 1'b1;
    step();
    step();

    // Reset values
    check_flags("rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_tec", dut_if.tec, 0);
    check_val("rst_rec", dut_if.rec, 0);
    check_irq("rst", 1'b0, 0);
    reset_i = 1'b0;
    step();

    // TEC climbs to WARNING at 96, PASSIVE at 128, state one cycle behind
    dut_if.tec_inc8 = 1'b1;
    repeat (12) step();
    dut_if.tec_inc8 = 1'b0;
    check_val("t96_tec", dut_if.tec, 96);
    check_val("t96_lag", dut_if.fstate, 0);
    step();
    check_flags("t96", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_irq("t96", 1'b1, 1);
    step();
    check_val("t96_irq_clr", dut_if.irqsig, 0);
    dut_if.tec_inc8 = 1'b1;
    repeat (4) step();
    dut_if.tec_inc8 = 1'b0;
    check_val("t128_tec", dut_if.tec, 128);
    check_val("t128_lag", dut_if.fstate, 1);
    step();
    check_flags("t128", 2, 1'b0, 1'b0, 1'b1, 1'b0);
    check_irq("t128", 1'b1, 2);

    // REC preload to 90, then inc8+inc1+dec1 -> 99 with dec ignored
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_val("rst2_fstate", dut_if.fstate, 0);
    check_val("rst2_tec", dut_if.tec, 0);
    dut_if.rec_inc8 = 1'b1;
    repeat (11) step();
    dut_if.rec_inc8 = 1'b0;
    dut_if.rec_inc1 = 1'b1;
    repeat (2) step();
    dut_if.rec_inc1 = 1'b0;
    check_val("r90_rec", dut_if.rec, 90);
    check_val("r90_fstate", dut_if.fstate, 0);
    dut_if.rec_inc8 = 1'b1; dut_if.rec_inc1 = 1'b1; dut_if.rec_dec1 = 1'b1;
    step();
    clear_inputs();
    check_val("r99_rec", dut_if.rec, 99);
    step();
    check_val("r99_fstate", dut_if.fstate, 1);

    // REC 140 -> dec1 drops to 119; PASSIVE -> WARNING directly
    dut_if.rec_inc8 = 1'b1;
    repeat (5) step();
    dut_if.rec_inc8 = 1'b0;
    dut_if.rec_inc1 = 1'b1;
    step();
    dut_if.rec_inc1 = 1'b0;
    step();
    check_val("r140_rec", dut_if.rec, 140);
    check_val("r140_fstate", dut_if.fstate, 2);
    dut_if.rec_dec1 = 1'b1;
    step();
    dut_if.rec_dec1 = 1'b0;
    check_val("r119_rec", dut_if.rec, 119);
    check_val("r119_lag", dut_if.fstate, 2);
    step();
    check_flags("r119", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_irq("r119", 1'b1, 1);
    dut_if.rec_dec1 = 1'b1;
    step();
    dut_if.rec_dec1 = 1'b0;
    check_val("r118_rec", dut_if.rec, 118);

    // TEC 248 -> 243 -> +7 = 250 -> inc8 saturates at 256 -> BUSOFF
    dut_if.tec_inc8 = 1'b1;
    repeat (31) step();
    dut_if.tec_inc8 = 1'b0;
    check_val("t248_tec", dut_if.tec, 248);
    dut_if.tec_dec1 = 1'b1;
    repeat (5) step();
    dut_if.tec_inc8 = 1'b1;
    step();
    clear_inputs();
    check_val("t250_tec", dut_if.tec, 250);
    check_val("t250_fstate", dut_if.fstate, 2);
    dut_if.tec_inc8 = 1'b1;
    step();
    dut_if.tec_inc8 = 1'b0;
    check_val("t256_tec", dut_if.tec, 256);
    step();
    check_flags("boff", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    check_irq("boff", 1'b1, 3);
    dut_if.tec_inc8 = 1'b1; dut_if.rec_inc1 = 1'b1;
    step();
    clear_inputs();
    dut_if.tec_dec1 = 1'b1; dut_if.rec_dec1 = 1'b1;
    step();
    clear_inputs();
    check_val("boff_tec_frozen", dut_if.tec, 256);
    check_val("boff_rec_frozen", dut_if.rec, 118);

    // Recovery with auto_recover=0: 128 sequences incl. one restarted, then host request
    dut_if.bit_tick = 1'b1; dut_if.bus_level = 1'b1;
    repeat (5) step();
    dut_if.bus_level = 1'b0;
    step();
    dut_if.bus_level = 1'b1;
    repeat (128 * 11) step();
    dut_if.bit_tick = 1'b0;
    step();
    check_val("rec_wait_fstate", dut_if.fstate, 3);
    dut_if.recover_req = 1'b1;
    step();
    dut_if.recover_req = 1'b0;
    check_val("req_pend_fstate", dut_if.fstate, 3);
    step();
    check_flags("recov", 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check_irq("recov", 1'b1, 4);
    step();
    check_flags("recov_done", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_irq("recov_done", 1'b1, 0);
    check_val("recov_tec", dut_if.tec, 0);
    check_val("recov_rec", dut_if.rec, 0);
    step();
    check_val("recov_irq_clr", dut_if.irqsig, 0);

    // Reset during BUSOFF after 60 sequences aborts recovery
    dut_if.tec_inc8 = 1'b1;
    repeat (32) step();
    dut_if.tec_inc8 = 1'b0;
    step();
    check_val("boff2_fstate", dut_if.fstate, 3);
    dut_if.bit_tick = 1'b1; dut_if.bus_level = 1'b1;
    repeat (60 * 11) step();
    dut_if.bit_tick = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_flags("abort", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("abort_tec", dut_if.tec, 0);
    check_val("abort_rec", dut_if.rec, 0);
    check_irq("abort", 1'b0, 0);

    // Fresh bus-off with auto_recover=1 needs the full 128 sequences again
    dut_if.tec_inc8 = 1'b1;
    repeat (32) step();
    dut_if.tec_inc8 = 1'b0;
    step();
    check_val("boff3_fstate", dut_if.fstate, 3);
    dut_if.auto_recover = 1'b1;
    dut_if.bit_tick = 1'b1; dut_if.bus_level = 1'b1;
    repeat (5) step();
    dut_if.bus_level = 1'b0;
    step();
    dut_if.bus_level = 1'b1;
    repeat (128 * 11 - 1) step();
    dut_if.bit_tick = 1'b0;
    step();
    check_val("auto_short_fstate", dut_if.fstate, 3);
    dut_if.bit_tick = 1'b1;
    step();
    dut_if.bit_tick = 1'b0;
    check_val("auto_last_fstate", dut_if.fstate, 3);
    step();
    check_val("auto_recov_fstate", dut_if.fstate, 4);
    check_irq("auto_recov", 1'b1, 4);
    step();
    check_val("auto_done_fstate", dut_if.fstate, 0);
    check_val("auto_done_tec", dut_if.tec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
